single_pe: RTL and testbench

- Single multiply-accumulate processing element (PE) for a systolic convolution array.
- Each cycle it computes p_sum + in_a × weight and registers the result on out_conv.
- Operand a passes through to the right neighbour on out_a; the weight passes down to the next PE on out_b.
- The weight can be held (weight-stationary) by deasserting b_en.

---
 rtl/single_pe.sv | 60 ++++++
 tb/tb_single_pe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/single_pe.sv
// single_pe: one multiply-accumulate cell of a weight-stationary systolic array.
// Optional build macro SINGLE_PE_SAT_EN clamps out_conv instead of wrapping.
module single_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              b_en,
    input  logic [ACC_W-1:0]  p_sum,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ACC_W-1:0]  out_conv
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [ACC_W-1:0]  conv_reg;
    logic [DATA_W-1:0] w;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  conv_nxt;

    // Full-precision MAC; a freshly loaded weight is used in the same cycle.
    always_comb begin
        w    = b_en ? in_b : b_reg;
        prod = PROD_W'(in_a) * PROD_W'(w);
        sum  = SUM_W'(prod) + SUM_W'(p_sum);
`ifdef SINGLE_PE_SAT_EN
        conv_nxt = (|sum[SUM_W-1:ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
        conv_nxt = ACC_W'(sum);
`endif
    end

    // Pipeline registers: activation pass-through, held weight, MAC result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            conv_reg <= '0;
        end else begin
            a_reg    <= in_a;
            if (b_en) begin
                b_reg <= in_b;
            end
            conv_reg <= conv_nxt;
        end
    end

    assign out_a    = a_reg;
    assign out_b    = b_reg;
    assign out_conv = conv_reg;

endmodule

// File: tb/tb_single_pe.sv
// tb_single_pe: directed vectors with a queue scoreboard for single_pe.
// Expected values are hand-computed; the monitor pops one per clock.
module tb_single_pe;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] conv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       b_en = 1'b0;
    logic [7:0] p_sum = '0;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] out_conv;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef SINGLE_PE_SAT_EN
    localparam logic [7:0] OVF_EXP = 8'd255;
`else
    localparam logic [7:0] OVF_EXP = 8'd144;
`endif

    single_pe #(.DATA_W(8), .ACC_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_a(in_a),
        .in_b(in_b),
        .b_en(b_en),
        .p_sum(p_sum),
        .out_a(out_a),
        .out_b(out_b),
        .out_conv(out_conv)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_a"}, out_a, 8'd0);
        chk({tag, "_out_b"}, out_b, 8'd0);
        chk({tag, "_out_conv"}, out_conv, 8'd0);
    endtask

    // Apply a vector at the falling edge and queue its expected result.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic en,
                         input logic [7:0] p, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        b_en  = en;
        p_sum = p;
        e.a = ea;
        e.b = eb;
        e.conv = ec;
        q.push_back(e);
    endtask

    // Monitor: just after each rising edge, compare against the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && q.size() > 0) begin
                e = q.pop_front();
                chk("mon_out_a", out_a, e.a);
                chk("mon_out_b", out_b, e.b);
                chk("mon_out_conv", out_conv, e.conv);
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1;
        rst = 1'b0;
        in_a = 8'd7;
        in_b = 8'd9;
        p_sum = 8'd4;
        b_en = 1'b1;
        #2;
        chk_zero("rst_async");
        // Held reset with toggling inputs across edges.
        @(negedge clk);
        in_a = 8'd9;
        in_b = 8'd7;
        p_sum = 8'd40;
        @(negedge clk);
        chk_zero("rst_held");

        // Release and basic MAC.
        rst = 1'b1;
        in_a = 8'd1;
        in_b = 8'd3;
        b_en = 1'b1;
        p_sum = 8'd0;
        q.push_back('{a: 8'd1, b: 8'd3, conv: 8'd3});
        drive(8'd2, 8'd5, 1'b1, 8'd3, 8'd2, 8'd5, 8'd13);
        // Weight hold then reload.
        drive(8'd1, 8'd3, 1'b0, 8'd3, 8'd1, 8'd5, 8'd8);
        drive(8'd1, 8'd3, 1'b1, 8'd3, 8'd1, 8'd3, 8'd6);
        // Overflow and boundary.
        drive(8'd20, 8'd20, 1'b1, 8'd0, 8'd20, 8'd20, OVF_EXP);
        drive(8'd0, 8'd7, 1'b1, 8'd255, 8'd0, 8'd7, 8'd255);
        drive(8'd16, 8'd16, 1'b1, 8'd1, 8'd16, 8'd16,
              OVF_EXP == 8'd255 ? 8'd255 : 8'd1);

        // Reset, then hold the cleared weight.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("rst_between");
        @(negedge clk);
        rst = 1'b1;
        in_a = 8'd9;
        in_b = 8'd9;
        b_en = 1'b0;
        p_sum = 8'd11;
        q.push_back('{a: 8'd9, b: 8'd0, conv: 8'd11});

        // Stream, then reset mid-operation with a vector in flight.
        drive(8'd3, 8'd4, 1'b1, 8'd10, 8'd3, 8'd4, 8'd22);
        drive(8'd5, 8'd6, 1'b1, 8'd1, 8'd5, 8'd6, 8'd31);
        @(negedge clk);
        in_a = 8'd7;
        in_b = 8'd7;
        b_en = 1'b1;
        p_sum = 8'd0;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        chk_zero("rst_mid_edge");
        @(negedge clk);
        rst = 1'b1;
        in_a = 8'd2;
        in_b = 8'd5;
        b_en = 1'b1;
        p_sum = 8'd3;
        q.push_back('{a: 8'd2, b: 8'd5, conv: 8'd13});

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
